// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch (read-only) port and a data (read/write) port
// onto one synchronous memory interface. Each access takes three cycles:
// grant in IDLE, address phase (F_ACC/D_ACC), ack phase (F_DONE/D_DONE).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; without it data
// always wins a simultaneous request.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [7:0]  f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [7:0]  m_addr,
  output logic        m_we,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_ACC  = 3'd1,
    F_DONE = 3'd2,
    D_ACC  = 3'd3,
    D_DONE = 3'd4
  } state_t;

  state_t state, next_state;
  logic   grant_f, grant_d;

`ifdef MEM_ARB_RR_EN
  // 1 = data was served last, so fetch wins the first tie after reset
  logic last_served;
`endif

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Arbitration in IDLE and the fixed walk through the access phases
  always_comb begin
    next_state = state;
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
          if (last_served) grant_f = 1'b1;
          else             grant_d = 1'b1;
`else
          grant_d = 1'b1;
`endif
        end else if (f_req) begin
          grant_f = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_f) next_state = F_ACC;
        if (grant_d) next_state = D_ACC;
      end
      F_ACC:   next_state = F_DONE;
      F_DONE:  next_state = IDLE;
      D_ACC:   next_state = D_DONE;
      D_DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  // Remember which port won the most recent grant for the next tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       last_served <= 1'b1;
    else if (grant_f) last_served <= 1'b0;
    else if (grant_d) last_served <= 1'b1;
  end
`endif

  // Latch the granted request into the memory port and capture read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_addr  <= 8'h00;
      m_we    <= 1'b0;
      m_wdata <= 16'h0000;
      owner   <= 1'b0;
      f_rdata <= 16'h0000;
      d_rdata <= 16'h0000;
    end else begin
      if (grant_f) begin
        m_addr <= f_addr;
        m_we   <= 1'b0;
        owner  <= 1'b0;
      end
      if (grant_d) begin
        m_addr  <= d_addr;
        m_we    <= d_we;
        m_wdata <= d_wdata;
        owner   <= 1'b1;
      end
      if (state == F_ACC) f_rdata <= m_rdata;
      if (state == D_ACC) begin
        // m_we still holds the latched direction here; writes leave d_rdata alone
        if (!m_we) d_rdata <= m_rdata;
        m_we <= 1'b0;
      end
    end
  end

  // Acks and busy decode straight from the state so reset clears them at once
  always_comb begin
    f_ack = (state == F_DONE);
    d_ack = (state == D_DONE);
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter with a scoreboard queue of
// expected acks, checked by a monitor on the falling clock edge.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [7:0]  m_addr;
  logic        m_we;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        busy;
  logic        owner;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic [15:0] mem [256];

  mem_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_ack   (f_ack),
    .f_rdata (f_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_addr  (m_addr),
    .m_we    (m_we),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .busy    (busy),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents start as {addr, ~addr}, except 0x05 which holds 0x1234
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0], ~i[7:0]};
    mem[5] = 16'h1234;
  end

  // Synchronous write port, read data follows the registered address
  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
  end
  assign m_rdata = mem[m_addr];

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic fr, input logic [7:0] fa,
                                input logic dr, input logic dw,
                                input logic [7:0] da, input logic [15:0] dd);
    f_req   = fr;
    f_addr  = fa;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
  endtask

  // Monitor: every ack pops one expectation and compares port and data
  always @(negedge clk) begin
    if (reset) begin
      if (f_ack && d_ack) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL dual_ack: got both acks, expected at most one");
      end else if (f_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_ack: got f_ack=%0b d_ack=%0b, expected none", f_ack, d_ack);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("ack_port", {15'd0, d_ack}, {15'd0, e.port});
          check_output("ack_data", d_ack ? d_rdata : f_rdata, e.data);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic got;
    reset = 1'b0;
    apply_stimulus(1'b1, 8'h03, 1'b1, 1'b0, 8'h04, 16'h0000);
    #12;
    check_output("rst_f_ack",   {15'd0, f_ack}, 16'h0000);
    check_output("rst_d_ack",   {15'd0, d_ack}, 16'h0000);
    check_output("rst_f_rdata", f_rdata, 16'h0000);
    check_output("rst_d_rdata", d_rdata, 16'h0000);
    check_output("rst_m_addr",  {8'd0, m_addr}, 16'h0000);
    check_output("rst_m_we",    {15'd0, m_we}, 16'h0000);
    check_output("rst_m_wdata", m_wdata, 16'h0000);
    check_output("rst_busy",    {15'd0, busy}, 16'h0000);
    check_output("rst_owner",   {15'd0, owner}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

`ifdef MEM_ARB_RR_EN
    // Tie held from reset: fetch, data, fetch, data
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{1'b0, 16'h03FC});
      tick();
      check_output("rr_owner_f", {15'd0, owner}, 16'h0000);
      tick();
      check_output("rr_f_ack", {15'd0, f_ack}, 16'h0001);
      tick();
      exp_q.push_back('{1'b1, 16'h04FB});
      tick();
      check_output("rr_owner_d", {15'd0, owner}, 16'h0001);
      tick();
      check_output("rr_d_ack", {15'd0, d_ack}, 16'h0001);
      tick();
    end
    apply_stimulus(1'b0, 8'h03, 1'b0, 1'b0, 8'h04, 16'h0000);
    tick();
`else
    // Tie under fixed priority: data every 3 cycles, fetch starved
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{1'b1, 16'h04FB});
      tick();
      check_output("fp_owner_d", {15'd0, owner}, 16'h0001);
      tick();
      check_output("fp_d_ack", {15'd0, d_ack}, 16'h0001);
      check_output("fp_no_f_ack", {15'd0, f_ack}, 16'h0000);
      tick();
      check_output("fp_idle_busy", {15'd0, busy}, 16'h0000);
    end
    d_req = 1'b0;
    exp_q.push_back('{1'b0, 16'h03FC});
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      tick();
      if (f_ack) got = 1'b1;
    end
    check_output("fp_f_follows", {15'd0, got}, 16'h0001);
    f_req = 1'b0;
    tick();
`endif

    // Fetch read of 0x05
    apply_stimulus(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 16'h0000);
    exp_q.push_back('{1'b0, 16'h1234});
    tick();
    check_output("fr_m_addr", {8'd0, m_addr}, 16'h0005);
    check_output("fr_m_we",   {15'd0, m_we}, 16'h0000);
    check_output("fr_busy",   {15'd0, busy}, 16'h0001);
    check_output("fr_owner",  {15'd0, owner}, 16'h0000);
    check_output("fr_no_ack_early", {15'd0, f_ack}, 16'h0000);
    tick();
    check_output("fr_f_ack", {15'd0, f_ack}, 16'h0001);
    f_req = 1'b0;
    tick();
    check_output("fr_ack_drop", {15'd0, f_ack}, 16'h0000);

    // Data write 0xBEEF to 0x10; d_rdata keeps the previous read value
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 16'hBEEF);
    exp_q.push_back('{1'b1, 16'h04FB});
    tick();
    check_output("dw_m_we",    {15'd0, m_we}, 16'h0001);
    check_output("dw_m_addr",  {8'd0, m_addr}, 16'h0010);
    check_output("dw_m_wdata", m_wdata, 16'hBEEF);
    check_output("dw_owner",   {15'd0, owner}, 16'h0001);
    tick();
    check_output("dw_m_we_off", {15'd0, m_we}, 16'h0000);
    check_output("dw_d_ack",    {15'd0, d_ack}, 16'h0001);
    d_req = 1'b0;
    tick();

    // Data read back of 0x10
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 16'h0000);
    exp_q.push_back('{1'b1, 16'hBEEF});
    tick();
    check_output("dr_m_we", {15'd0, m_we}, 16'h0000);
    tick();
    d_req = 1'b0;
    tick();

    // Second write: d_rdata must hold 0xBEEF
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 16'h5555);
    exp_q.push_back('{1'b1, 16'hBEEF});
    tick();
    tick();
    d_req = 1'b0;
    tick();

    // Stability: fetch 0x05, address changes to 0x06 during F_ACC
    apply_stimulus(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 16'h0000);
    exp_q.push_back('{1'b0, 16'h1234});
    tick();
    f_addr = 8'h06;
    #1;
    check_output("st_m_addr", {8'd0, m_addr}, 16'h0005);
    tick();
    check_output("st_m_addr_done", {8'd0, m_addr}, 16'h0005);
    f_req = 1'b0;
    tick();

    // Fetch of the written location 0x20
    apply_stimulus(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 16'h0000);
    exp_q.push_back('{1'b0, 16'h5555});
    tick();
    tick();
    f_req = 1'b0;
    tick();

    // Reset in the D_ACC cycle of a write aborts it without an ack
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 16'h1111);
    tick();
    check_output("rw_m_we_before", {15'd0, m_we}, 16'h0001);
    reset = 1'b0;
    #1;
    check_output("rw_m_we",  {15'd0, m_we}, 16'h0000);
    check_output("rw_d_ack", {15'd0, d_ack}, 16'h0000);
    check_output("rw_busy",  {15'd0, busy}, 16'h0000);
    check_output("rw_owner", {15'd0, owner}, 16'h0000);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_output("rw_busy_after", {15'd0, busy}, 16'h0000);
    check_output("rw_no_write", mem[8'h30], 16'h30CF);

    check_output("queue_drained", exp_q.size()[15:0], 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low
- f_req  input  1  fetch port request; held until f_ack
- f_addr  input  8  fetch read address
- f_ack  output  1  one-cycle pulse; f_rdata valid
- f_rdata  output  16  fetch read data, held until next fetch ack
- d_req  input  1  data port request; held until d_ack
- d_we  input  1  data port write enable (1 = write, 0 = read)
- d_addr  input  8  data port address
- d_wdata  input  16  data port write data
- d_ack  output  1  one-cycle pulse; access complete, d_rdata valid for reads
- d_rdata  output  16  data read data, held until next data read ack
- m_addr  output  8  memory address, registered
- m_we  output  1  memory write strobe, registered
- m_wdata  output  16  memory write data, registered
- m_rdata  input  16  memory read data; valid the cycle after m_addr is presented
- busy  output  1  high whenever the FSM is not in IDLE
- owner  output  1  current or last grantee: 0 = fetch, 1 = data

Function
REQ-003 The FSM SHALL have the states IDLE, F_ACC, F_DONE, D_ACC and D_DONE.
REQ-004 In IDLE, f_req and d_req SHALL be sampled on each rising edge.
- Only f_req high -> F_ACC.
- Only d_req high -> D_ACC.
- Neither high -> stay in IDLE.
REQ-005 On the edge that grants a port, the arbiter SHALL latch that port's address (and d_we and d_wdata for data) into m_addr, m_we and m_wdata; owner SHALL update on the same edge.
REQ-006 In F_ACC, m_we SHALL be 0; the next state SHALL be F_DONE unconditionally.
REQ-007 On entry to F_DONE, f_rdata SHALL capture m_rdata and f_ack SHALL be high for exactly that one cycle; the next state SHALL be IDLE.
REQ-008 In D_ACC, m_we SHALL equal the latched d_we for exactly one cycle; the next state SHALL be D_DONE, and m_we SHALL return to 0.
REQ-009 On entry to D_DONE, d_ack SHALL pulse for one cycle; for reads d_rdata SHALL capture m_rdata, and for writes d_rdata SHALL be unchanged.
REQ-010 Latency SHALL be 2 cycles from the granting edge to the ack, and throughput at most one access per 3 cycles.
REQ-011 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-012 Changes to f_addr, d_addr, d_we or d_wdata after the grant SHALL NOT affect the access in progress.
REQ-013 A request asserted while busy is high SHALL be ignored until IDLE, with no loss, provided it is still held.
REQ-014 f_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-015 While reset is low, all of the following SHALL hold immediately, independent of clk:
- state = IDLE
- f_ack = d_ack = 0
- f_rdata = d_rdata = 0
- m_addr = 0, m_we = 0, m_wdata = 0
- busy = 0, owner = 0
- internal last-served flag = 1 (data)
REQ-016 Reset asserted mid-access SHALL abort it: m_we drops at once, no ack is issued, and the access is not retried.
REQ-017 The first rising edge after reset deasserts SHALL perform normal IDLE sampling.

Configuration
REQ-018 The macro MEM_ARB_RR_EN SHALL select the policy for simultaneous requests in IDLE.
- Defined: round-robin. On simultaneous requests the port not served last wins; the last-served flag updates at every grant. After reset, fetch wins the first tie.
- Undefined: fixed priority. On simultaneous requests data always wins, and the last-served flag is unused.
REQ-019 Single-requester behaviour SHALL be identical under both settings.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Fetch read: m_rdata model returns 16'h1234 at 8'h05; f_req with f_addr = 8'h05 -> m_addr = 8'h05 and m_we = 0 in F_ACC; f_ack pulses 2 cycles after grant with f_rdata = 16'h1234.
- Data write: d_req, d_we = 1, d_addr = 8'h10, d_wdata = 16'hBEEF -> exactly one cycle with m_we = 1, m_addr = 8'h10, m_wdata = 16'hBEEF; d_ack one cycle later; d_rdata unchanged.
- Tie, MEM_ARB_RR_EN defined: f_req and d_req held high from reset -> acks alternate fetch, data, fetch, data, with owner toggling 0, 1, 0, 1.
- Tie, MEM_ARB_RR_EN undefined: both held high -> d_ack repeats every 3 cycles; f_ack never asserts until d_req drops; f_ack follows within 3 cycles.
- Reset mid-write: reset pulled low in the D_ACC cycle -> m_we = 0 immediately; no d_ack; busy = 0, owner = 0.
- Stability: f_addr changed from 8'h05 to 8'h06 during F_ACC -> m_addr stays 8'h05; f_rdata holds the data for 8'h05.
